// File: rtl/la_capture_core.sv
// On-chip logic-analyser capture core: pre-trigger ring buffer, masked level/edge
// trigger, valid/ready readout. Define LA_SAMPLE_DECIM_EN to add sample decimation (decim_i).
//
// state | meaning
// IDLE  | waiting for an arm pulse
// FILL  | collecting pre-trigger samples, trigger ignored
// ARMED | circular capture, watching for a hit
// POST  | writing the post-trigger samples
// DONE  | capture complete, buffer may be read
// READ  | streaming DEPTH samples, oldest first
module la_capture_core #(
    parameter int DATA_W = 23,
    parameter int TRIG_W = 10,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_value_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic              trig_mode_i,
    input  logic [ADDR_W-1:0] pre_trig_i,
`ifdef LA_SAMPLE_DECIM_EN
    input  logic [7:0]        decim_i,
`endif
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              rd_start_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              done_o,
    output logic [2:0]        state_o,
    output logic [ADDR_W-1:0] trig_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4,
        S_READ  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    state_t state, state_next;

    logic [DATA_W-1:0] data_r;
    logic [TRIG_W-1:0] trig_r;
    logic [ADDR_W-1:0] cfg_pre;
    logic              cfg_mode;
    logic [TRIG_W-1:0] cfg_value;
    logic [TRIG_W-1:0] cfg_mask;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] trig_addr;
    logic              prev_match;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_issued;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;

    logic              strobe;
    logic              match;
    logic              hit;
    logic              fill_done;
    logic [ADDR_W-1:0] post_len;
    logic              rd_advance;
    logic              rd_more;
    logic              rd_fetch;

    logic              load_arm;
    logic              load_trig;
    logic              do_write;
    logic              rd_init;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef LA_SAMPLE_DECIM_EN
    logic [7:0] cfg_decim;
    logic [7:0] div_cnt;

    assign strobe = (div_cnt == 8'd0);

    // Down-counter restarts at zero on arm so the first FILL cycle is a sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_decim <= 8'd0;
            div_cnt   <= 8'd0;
        end else if (load_arm) begin
            cfg_decim <= decim_i;
            div_cnt   <= 8'd0;
        end else if (state == S_FILL || state == S_ARMED || state == S_POST) begin
            div_cnt <= strobe ? cfg_decim : div_cnt - 8'd1;
        end
    end
`else
    assign strobe = 1'b1;
`endif

    assign match     = ((trig_r ^ cfg_value) & cfg_mask) == '0;
    assign hit       = strobe && (cfg_mode ? (match && !prev_match) : match);
    assign fill_done = ({1'b0, fill_cnt} + (ADDR_W + 1)'(1)) >= {1'b0, cfg_pre};
    assign post_len  = LAST_IDX - cfg_pre;

    assign rd_advance = !rd_valid || out_ready_i;
    assign rd_more    = (rd_issued != FULL_CNT);
    assign rd_fetch   = (state == S_READ) && rd_advance && rd_more && !abort_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_arm   = 1'b0;
        load_trig  = 1'b0;
        do_write   = 1'b0;
        rd_init    = 1'b0;
        if (abort_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm_i) begin
                        load_arm   = 1'b1;
                        state_next = S_FILL;
                    end
                end
                S_FILL: begin
                    if (strobe) begin
                        do_write = 1'b1;
                        if (fill_done) begin
                            state_next = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (strobe) begin
                        do_write = 1'b1;
                        if (hit) begin
                            load_trig  = 1'b1;
                            state_next = (post_len == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (strobe) begin
                        do_write = 1'b1;
                        if (post_cnt == ADDR_W'(1)) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (arm_i) begin
                        load_arm   = 1'b1;
                        state_next = S_FILL;
                    end else if (rd_start_i) begin
                        rd_init    = 1'b1;
                        state_next = S_READ;
                    end
                end
                S_READ: begin
                    if (rd_valid && out_ready_i && rd_last) begin
                        state_next = S_DONE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // pre_trig_i is ADDR_W bits wide, so it can never exceed DEPTH-1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_r     <= '0;
            trig_r     <= '0;
            cfg_pre    <= '0;
            cfg_mode   <= 1'b0;
            cfg_value  <= '0;
            cfg_mask   <= '0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            trig_addr  <= '0;
            prev_match <= 1'b0;
        end else begin
            data_r <= data_i;
            trig_r <= trig_i;
            if (load_arm) begin
                cfg_pre    <= pre_trig_i;
                cfg_mode   <= trig_mode_i;
                cfg_value  <= trig_value_i;
                cfg_mask   <= trig_mask_i;
                wr_ptr     <= '0;
                fill_cnt   <= '0;
                prev_match <= 1'b0;
            end else begin
                if (do_write) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (do_write && state == S_FILL) begin
                    fill_cnt <= fill_cnt + ADDR_W'(1);
                end
                if (strobe && (state == S_FILL || state == S_ARMED)) begin
                    prev_match <= match;
                end
                if (load_trig) begin
                    trig_addr <= wr_ptr;
                    post_cnt  <= post_len;
                end else if (do_write && state == S_POST) begin
                    post_cnt <= post_cnt - ADDR_W'(1);
                end
            end
        end
    end

    // One-entry output stage in front of the synchronous memory read;
    // the memory output only moves when the stage is empty or being consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_addr   <= '0;
            rd_issued <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else if (abort_i) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (rd_init) begin
            rd_addr   <= trig_addr - cfg_pre;
            rd_issued <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else if (state == S_READ && rd_advance) begin
            rd_valid <= rd_more;
            rd_last  <= (rd_issued == LAST_CNT);
            if (rd_more) begin
                rd_addr   <= rd_addr + ADDR_W'(1);
                rd_issued <= rd_issued + (ADDR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wr_ptr] <= data_r;
        end
        if (rd_fetch) begin
            rd_data <= mem[rd_addr];
        end
    end

    assign out_data_o  = rd_valid ? rd_data : '0;
    assign out_valid_o = rd_valid;
    assign out_last_o  = rd_last;
    assign done_o      = (state == S_DONE) || (state == S_READ);
    assign state_o     = state;
    assign trig_addr_o = trig_addr;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core at DEPTH=16; the decimation case runs only
// when LA_SAMPLE_DECIM_EN is defined.
module tb_la_capture_core;

    localparam int DATA_W = 23;
    localparam int TRIG_W = 10;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [DATA_W-1:0] data_i;
    logic [TRIG_W-1:0] trig_i;
    logic [TRIG_W-1:0] trig_value_i;
    logic [TRIG_W-1:0] trig_mask_i;
    logic              trig_mode_i;
    logic [ADDR_W-1:0] pre_trig_i;
`ifdef LA_SAMPLE_DECIM_EN
    logic [7:0]        decim_i;
`endif
    logic              arm_i;
    logic              abort_i;
    logic              rd_start_i;
    logic [DATA_W-1:0] out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              done_o;
    logic [2:0]        state_o;
    logic [ADDR_W-1:0] trig_addr_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit count_en    = 1'b1;
    bit trig_follow = 1'b1;

    always #5 clk_i = ~clk_i;

    la_capture_core #(
        .DATA_W(DATA_W),
        .TRIG_W(TRIG_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_i      (data_i),
        .trig_i      (trig_i),
        .trig_value_i(trig_value_i),
        .trig_mask_i (trig_mask_i),
        .trig_mode_i (trig_mode_i),
        .pre_trig_i  (pre_trig_i),
`ifdef LA_SAMPLE_DECIM_EN
        .decim_i     (decim_i),
`endif
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .rd_start_i  (rd_start_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .done_o      (done_o),
        .state_o     (state_o),
        .trig_addr_o (trig_addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (count_en)    data_i = cyc[DATA_W-1:0];
        if (trig_follow) trig_i = cyc[TRIG_W-1:0];
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done_o && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, done_o}, 32'd1);
    endtask

    // Reads one full stream; every valid cycle must show the sample still owed.
    task automatic read_stream(input string tag, input int first, input int step,
                               input logic [3:0] rpat);
        int n;
        int k;
        n = 0;
        k = 0;
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        chk({tag, "_lat1"}, {31'd0, out_valid_o}, 32'd0);
        tick();
        chk({tag, "_lat2"}, {31'd0, out_valid_o}, 32'd1);
        while (n < DEPTH && k < 200) begin
            out_ready_i = rpat[k % 4];
            if (out_valid_o) begin
                chk({tag, "_data"}, 32'(out_data_o), 32'(first + n * step));
                if (out_ready_i) begin
                    chk({tag, "_last"}, {31'd0, out_last_o}, {31'd0, (n == DEPTH - 1)});
                    n++;
                end
            end
            tick();
            k++;
        end
        out_ready_i = 1'b0;
        chk({tag, "_count"}, n, DEPTH);
        chk({tag, "_end_state"}, 32'(state_o), 32'd4);
        chk({tag, "_end_valid"}, {31'd0, out_valid_o}, 32'd0);
    endtask

    initial begin
        int c0;
        rst_ni       = 1'b0;
        data_i       = '0;
        trig_i       = '0;
        trig_value_i = 10'h005;
        trig_mask_i  = 10'h3FF;
        trig_mode_i  = 1'b0;
        pre_trig_i   = 4'd4;
`ifdef LA_SAMPLE_DECIM_EN
        decim_i      = 8'd0;
`endif
        arm_i        = 1'b0;
        abort_i      = 1'b0;
        rd_start_i   = 1'b0;
        out_ready_i  = 1'b0;
        ticks(3);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_last", {31'd0, out_last_o}, 32'd0);
        chk("rst_data", 32'(out_data_o), 32'd0);
        chk("rst_taddr", 32'(trig_addr_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Level trigger on registered value 5, pre=4; edge n samples value n.
        cyc    = 0;
        data_i = '0;
        trig_i = '0;
        arm_i  = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("t1_fill", 32'(state_o), 32'd1);
        ticks(4);
        chk("t1_armed", 32'(state_o), 32'd2);
        ticks(2);
        chk("t1_post", 32'(state_o), 32'd3);
        chk("t1_taddr", 32'(trig_addr_o), 32'd5);
        ticks(10);
        chk("t1_post_end", 32'(state_o), 32'd3);
        chk("t1_not_done", {31'd0, done_o}, 32'd0);
        tick();
        chk("t1_done_state", 32'(state_o), 32'd4);
        chk("t1_done", {31'd0, done_o}, 32'd1);
        read_stream("t1_rd", 1, 1, 4'b1111);
        read_stream("t1_rd_stall", 1, 1, 4'b1001);

        // Edge trigger: match already true at arm must not fire.
        trig_follow  = 1'b0;
        trig_i       = 10'h005;
        trig_mode_i  = 1'b1;
        pre_trig_i   = 4'd2;
        ticks(2);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("t2_fill", 32'(state_o), 32'd1);
        ticks(5);
        chk("t2_no_trig", 32'(state_o), 32'd2);
        trig_i = 10'h000;
        tick();
        trig_i = 10'h005;
        tick();
        chk("t2_still_armed", 32'(state_o), 32'd2);
        tick();
        chk("t2_post", 32'(state_o), 32'd3);
        chk("t2_taddr", 32'(trig_addr_o), 32'd7);
        ticks(12);
        chk("t2_not_done", {31'd0, done_o}, 32'd0);
        tick();
        chk("t2_done", {31'd0, done_o}, 32'd1);

        // mask=0 fires on the first ARMED cycle; pre=15 leaves no post samples.
        trig_mode_i = 1'b0;
        trig_mask_i = 10'h000;
        pre_trig_i  = 4'd15;
        c0    = int'(data_i);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        ticks(14);
        chk("t3_fill_end", 32'(state_o), 32'd1);
        tick();
        chk("t3_armed", 32'(state_o), 32'd2);
        tick();
        chk("t3_done_state", 32'(state_o), 32'd4);
        chk("t3_done", {31'd0, done_o}, 32'd1);
        chk("t3_taddr", 32'(trig_addr_o), 32'd15);
        read_stream("t3_rd", c0, 1, 4'b1111);

        // Abort during POST, then arm and abort together from IDLE.
        pre_trig_i = 4'd0;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        ticks(3);
        chk("t4_post", 32'(state_o), 32'd3);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t4_abort_state", 32'(state_o), 32'd0);
        chk("t4_abort_done", {31'd0, done_o}, 32'd0);
        chk("t4_abort_valid", {31'd0, out_valid_o}, 32'd0);
        arm_i   = 1'b1;
        abort_i = 1'b1;
        tick();
        arm_i   = 1'b0;
        abort_i = 1'b0;
        chk("t4_arm_abort", 32'(state_o), 32'd0);
        tick();
        chk("t4_stay_idle", 32'(state_o), 32'd0);

        // Asynchronous reset in the middle of a readout.
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        wait_done("t5_wait_done", 40);
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        tick();
        chk("t5_valid_before", {31'd0, out_valid_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("t5_rst_state", 32'(state_o), 32'd0);
        chk("t5_rst_done", {31'd0, done_o}, 32'd0);
        chk("t5_rst_data", 32'(out_data_o), 32'd0);
        #2 rst_ni = 1'b1;
        tick();
        chk("t5_after_rst", 32'(state_o), 32'd0);

`ifdef LA_SAMPLE_DECIM_EN
        // Every fourth cycle is a sample: the stored stream steps by 4.
        decim_i    = 8'd3;
        pre_trig_i = 4'd4;
        c0    = int'(data_i);
        arm_i = 1'b1;
        tick();
        arm_i   = 1'b0;
        decim_i = 8'd0;
        wait_done("t6_wait_done", 200);
        chk("t6_taddr", 32'(trig_addr_o), 32'd4);
        read_stream("t6_rd", c0, 4, 4'b1111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
